// File: rtl/spi_cmd_pkg.sv
// Shared command codes, FSM encoding and sample width for the SPI sensor encoder/decoder pair.
// Only codes below NUM_REGS are legal read commands.
package spi_cmd_pkg;

  localparam int CMD_WIDTH = 3;
  localparam int SAMPLE_W  = 16;
  localparam int NUM_REGS  = 6;

  typedef enum logic [CMD_WIDTH-1:0] {
    CMD_ROLL_ANG  = 3'd0,
    CMD_ROLL_LIN  = 3'd1,
    CMD_PITCH_ANG = 3'd2,
    CMD_PITCH_LIN = 3'd3,
    CMD_YAW_ANG   = 3'd4,
    CMD_YAW_LIN   = 3'd5
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_LO = 2'd1,
    WAIT_HI = 2'd2,
    DONE    = 2'd3
  } state_e;

  typedef logic [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/spi_sample_regs.sv
// Six-entry sample holding file: one write port, registered read port (1-cycle latency).
// No backpressure; a same-cycle write and read of one entry returns the pre-write value.
module spi_sample_regs
  import spi_cmd_pkg::*;
#(
  parameter int CMD_W = CMD_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [CMD_W-1:0]    wr_sel,
  input  logic [SAMPLE_W-1:0] wr_data,
  input  logic [CMD_W-1:0]    rd_sel,
  output logic [SAMPLE_W-1:0] rd_data
);

  sample_t regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en && (int'(wr_sel) < NUM_REGS)) regs[wr_sel] <= wr_data;
      // Selectors past the last entry read as zero.
      rd_data <= (int'(rd_sel) < NUM_REGS) ? regs[rd_sel] : '0;
    end
  end

endmodule

// File: rtl/spi_decoder.sv
// Collects a two-byte (low then high) sensor response per read command; data_valid follows the
// high byte by one cycle. No backpressure: stray bytes and commands while not expected are dropped.
module spi_decoder
  import spi_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CMD_W          = CMD_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_start,
  input  logic [CMD_W-1:0]    command,
  input  logic                rx_dv,
  input  logic [7:0]          rx_byte,
  input  logic [CMD_W-1:0]    rd_sel,
  output logic [SAMPLE_W-1:0] data_out,
  output logic [CMD_W-1:0]    data_cmd,
  output logic                data_valid,
  output logic                busy,
  output logic                error,
  output logic [SAMPLE_W-1:0] rd_data
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e           state;
  logic [TW-1:0]    timer;
  logic [CMD_W-1:0] cmd_q;
  logic [7:0]       lo_q;
  logic             cmd_ok;
  logic             timer_last;

  assign cmd_ok     = int'(command) < NUM_REGS;
  assign timer_last = timer == TW'(TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      timer      <= '0;
      cmd_q      <= '0;
      lo_q       <= '0;
      data_out   <= '0;
      data_cmd   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      error      <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      error      <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_start) begin
            if (cmd_ok) begin
              cmd_q <= command;
              timer <= '0;
              busy  <= 1'b1;
              state <= WAIT_LO;
            end else begin
              error <= 1'b1;
            end
          end
        end
        WAIT_LO: begin
          // A byte arriving on the last timer count still counts.
          if (rx_dv) begin
            lo_q  <= rx_byte;
            timer <= '0;
            state <= WAIT_HI;
          end else if (timer_last) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        WAIT_HI: begin
          if (rx_dv) begin
            data_out   <= {rx_byte, lo_q};
            data_cmd   <= cmd_q;
            data_valid <= 1'b1;
            busy       <= 1'b0;
            state      <= DONE;
          end else if (timer_last) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DONE: begin
          timer <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The holding register is written during the DONE cycle from the already-registered sample.
  spi_sample_regs #(.CMD_W(CMD_W)) u_regs (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (state == DONE),
    .wr_sel  (data_cmd),
    .wr_data (data_out),
    .rd_sel  (rd_sel),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_spi_decoder.sv
// Randomized transaction-level bench for spi_decoder with a small TB-side result model.
module tb_spi_decoder;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_start = 1'b0;
  logic [2:0]  command = '0;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic [2:0]  rd_sel = '0;
  logic [15:0] data_out;
  logic [2:0]  data_cmd;
  logic        data_valid;
  logic        busy;
  logic        error;
  logic [15:0] rd_data;

  spi_decoder #(.TIMEOUT_CYCLES(T), .CMD_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_start  (cmd_start),
    .command    (command),
    .rx_dv      (rx_dv),
    .rx_byte    (rx_byte),
    .rd_sel     (rd_sel),
    .data_out   (data_out),
    .data_cmd   (data_cmd),
    .data_valid (data_valid),
    .busy       (busy),
    .error      (error),
    .rd_data    (rd_data)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: last published sample and the six holding registers.
  logic [15:0] hold [6];
  logic [15:0] exp_out = '0;
  logic [2:0]  exp_cmd = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change at negedge; outputs are observed at the following negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) hold[i] = '0;
    exp_out = '0;
    exp_cmd = '0;
  endtask

  task automatic sweep_regs(input string tag);
    for (int s = 0; s < 8; s++) begin
      rd_sel = 3'(s);
      tick();
      check($sformatf("%s_rd%0d", tag, s), rd_data, (s < 6) ? 32'(hold[s]) : 32'd0);
    end
  endtask

  task automatic wait_phase(input string ph, input int gap, input logic [7:0] b,
                            input bit stray, input logic [2:0] scmd, output bit aborted);
    aborted = 1'b0;
    for (int i = 0; i < gap; i++) begin
      if (stray && i == 0) begin
        cmd_start = 1'b1;
        command   = scmd;
      end
      tick();
      cmd_start = 1'b0;
      if (i + 1 == T) begin
        check({ph, "_timeout_err"}, error, 1);
        check({ph, "_timeout_busy"}, busy, 0);
        check({ph, "_timeout_dv"}, data_valid, 0);
        tick();
        check({ph, "_timeout_err_clr"}, error, 0);
        aborted = 1'b1;
        return;
      end
      check({ph, "_wait_busy"}, busy, 1);
      check({ph, "_wait_err"}, error, 0);
    end
    rx_dv   = 1'b1;
    rx_byte = b;
    tick();
    rx_dv   = 1'b0;
  endtask

  task automatic run_txn(input logic [2:0] cmd, input logic [7:0] lo, input logic [7:0] hi,
                         input int gap_lo, input int gap_hi, input bit stray);
    bit          ab;
    logic [15:0] old;
    if (stray) begin
      rx_dv   = 1'b1;
      rx_byte = 8'hAA;
      tick();
      rx_dv   = 1'b0;
      check("idle_rx_busy", busy, 0);
      check("idle_rx_dv", data_valid, 0);
    end
    if (cmd < 6) rd_sel = cmd;
    cmd_start = 1'b1;
    command   = cmd;
    tick();
    cmd_start = 1'b0;
    if (cmd >= 6) begin
      check("illegal_err", error, 1);
      check("illegal_busy", busy, 0);
      check("illegal_dv", data_valid, 0);
      rx_dv   = 1'b1;
      rx_byte = 8'hAA;
      tick();
      rx_dv   = 1'b0;
      check("illegal_err_clr", error, 0);
      check("illegal_rx_busy", busy, 0);
      tick();
      check("illegal_rx_dv", data_valid, 0);
      check("illegal_hold_out", data_out, exp_out);
      return;
    end
    check("start_busy", busy, 1);
    wait_phase("lo", gap_lo, lo, 1'b0, 3'd0, ab);
    if (!ab) begin
      check("lo_busy", busy, 1);
      check("lo_dv", data_valid, 0);
      wait_phase("hi", gap_hi, hi, stray, 3'((cmd + 1) % 6), ab);
    end
    if (!ab) begin
      check("hi_dv", data_valid, 1);
      check("hi_out", data_out, {hi, lo});
      check("hi_cmd", data_cmd, cmd);
      check("hi_busy", busy, 0);
      check("hi_err", error, 0);
      old = hold[cmd];
      tick();
      check("done_dv_clr", data_valid, 0);
      check("done_rd_old", rd_data, old);
      hold[cmd] = {hi, lo};
      exp_out   = {hi, lo};
      exp_cmd   = cmd;
    end
    check("hold_out", data_out, exp_out);
    check("hold_cmd", data_cmd, exp_cmd);
    sweep_regs("txn");
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out"}, data_out, 0);
    check({tag, "_cmd"}, data_cmd, 0);
    check({tag, "_dv"}, data_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, error, 0);
    check({tag, "_rd"}, rd_data, 0);
  endtask

  initial begin
    int gl, gh;
    model_reset();
    @(negedge clk);
    tick();
    tick();
    check_all_zero("rst");
    rst_n = 1'b1;
    tick();

    run_txn(3'd2, 8'h34, 8'h12, 1, 2, 1'b0);
    run_txn(3'd5, 8'h00, 8'h80, 0, 0, 1'b0);
    run_txn(3'd0, 8'h55, 8'h66, 1, T, 1'b0);
    run_txn(3'd7, 8'h00, 8'h00, 0, 0, 1'b0);
    run_txn(3'd6, 8'h00, 8'h00, 0, 0, 1'b0);
    run_txn(3'd4, 8'h11, 8'h22, 0, 2, 1'b1);
    run_txn(3'd3, 8'h99, 8'h88, T, 0, 1'b0);
    run_txn(3'd1, 8'hFE, 8'h7F, T - 1, T - 1, 1'b1);

    // Reset in the middle of a response drops the partial sample silently.
    rd_sel    = 3'd3;
    cmd_start = 1'b1;
    command   = 3'd3;
    tick();
    cmd_start = 1'b0;
    rx_dv     = 1'b1;
    rx_byte   = 8'h5A;
    tick();
    rx_dv     = 1'b0;
    rst_n     = 1'b0;
    tick();
    model_reset();
    check_all_zero("midrst");
    rst_n = 1'b1;
    tick();
    check("midrst_rel_err", error, 0);
    check("midrst_rel_dv", data_valid, 0);
    run_txn(3'd1, 8'h01, 8'h02, 0, 0, 1'b0);
    check("midrst_0201", data_out, 16'h0201);

    for (int n = 0; n < 40; n++) begin
      gl = ($urandom_range(0, 9) == 0) ? T + int'($urandom_range(0, 3)) :
           ($urandom_range(0, 7) == 0) ? T - 1 : int'($urandom_range(0, 3));
      gh = ($urandom_range(0, 9) == 0) ? T + int'($urandom_range(0, 3)) :
           ($urandom_range(0, 7) == 0) ? T - 1 : int'($urandom_range(0, 3));
      run_txn(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), gl, gh,
              1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_decoder.md
SPI_DECODER -- requirements
Module: spi_decoder

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 1024, max cycles waited for each response byte before abort.
REQ-002 Parameter: CMD_W, 3, width of the command code.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 cmd_start  input  1  one-cycle pulse; a read command was issued to the SPI master.
REQ-006 command  input  3  command code (0 roll-ang, 1 roll-lin, 2 pitch-ang, 3 pitch-lin, 4 yaw-ang, 5 yaw-lin), sampled with cmd_start.
REQ-007 rx_dv  input  1  one-cycle strobe; rx_byte holds a received byte.
REQ-008 rx_byte  input  8  byte received from the sensor on MISO.
REQ-009 rd_sel  input  3  selects a holding register for rd_data.
REQ-010 data_out  output  16  last assembled sample, {high, low}, two's complement.
REQ-011 data_cmd  output  3  command code belonging to data_out.
REQ-012 data_valid  output  1  one-cycle pulse; data_out/data_cmd are new.
REQ-013 busy  output  1  high while a response is being collected.
REQ-014 error  output  1  one-cycle pulse on timeout or illegal command.
REQ-015 rd_data  output  16  holding register selected by rd_sel; 0 for rd_sel 6 or 7.

Function
REQ-016 FSM states SHALL be IDLE, WAIT_LO, WAIT_HI, DONE.
REQ-017 IDLE: cmd_start with command 0-5 latches command, clears timer, -> WAIT_LO; command 6/7 -> error pulse next cycle, stay IDLE.
REQ-018 WAIT_LO: rx_dv latches rx_byte as low byte, clears timer, -> WAIT_HI.
REQ-019 WAIT_HI: rx_dv latches rx_byte as high byte, -> DONE.
REQ-020 DONE (one cycle): data_out={hi,lo}, data_cmd=latched command, data_valid=1, holding register[command] updated, -> IDLE.
REQ-021 Latency: data_valid asserted exactly 1 cycle after the high-byte rx_dv cycle.
REQ-022 Timer: 0..TIMEOUT_CYCLES-1 counter in WAIT_LO/WAIT_HI, increments each cycle without rx_dv; reaching TIMEOUT_CYCLES-1 without rx_dv -> error pulse, -> IDLE, no data_valid, holding registers unchanged.
REQ-023 rx_dv while IDLE or DONE SHALL be ignored.
REQ-024 cmd_start while busy SHALL be ignored (no restart, no error).
REQ-025 rx_dv and timer expiry in the same cycle: rx_dv wins.
REQ-026 busy=1 exactly in WAIT_LO and WAIT_HI.
REQ-027 data_out/data_cmd SHALL hold their value until the next DONE.
REQ-028 rd_data SHALL be a registered read, valid 1 cycle after rd_sel; a write and read of the same register in one cycle returns the old value.

Reset
REQ-029 rst_n low at a rising edge: state IDLE, timer 0, data_out 0, data_cmd 0, data_valid 0, busy 0, error 0, all six holding registers 0, rd_data 0.
REQ-030 Reset mid-transaction SHALL discard partial bytes with no data_valid or error pulse.

Structure
REQ-031 Command codes, state encoding and the 16-bit sample width SHALL live in shared package spi_cmd_pkg, also used by the encoder.
REQ-032 The six-entry holding register file SHALL be sub-module spi_sample_regs (write port from DONE, registered read port).

Verification
REQ-033 cmd_start command=2, rx_dv 0x34 then 0x12 -> data_valid once, data_out=0x1234, data_cmd=2, rd_sel=2 gives 0x1234.
REQ-034 cmd_start command=5, bytes 0x00, 0x80 -> data_out=0x8000 (-32768), only register 5 changes.
REQ-035 cmd_start command=0, one byte then silence for TIMEOUT_CYCLES -> error pulse, busy falls, no data_valid, register 0 unchanged.
REQ-036 cmd_start command=7 -> error pulse, busy stays 0; then rx_dv 0xAA -> ignored.
REQ-037 Second cmd_start between the two bytes -> ignored, data_cmd keeps the first command.
REQ-038 rst_n low after the low byte -> all outputs 0; following command=1 with 0x01, 0x02 -> data_out=0x0201.
